// File: rtl/apb_master_bridge.sv
// apb_master_bridge
// -----------------
// Single-outstanding APB3 requester. A valid/ready command is turned into one
// APB SETUP/ACCESS transfer, and exactly one rsp_valid pulse is returned per
// accepted command. Responses are not backpressured.
//
// Optional build macro: APB_MASTER_BRIDGE_TIMEOUT_EN
//   When defined, an ACCESS phase that sees p_ready low for TIMEOUT_CYCLES
//   consecutive cycles is aborted and reported with rsp_slverr = rsp_timeout = 1.
//   When undefined, ACCESS waits indefinitely and rsp_timeout is always 0.
//
// Ports
//   p_clk, p_reset         clock (rising edge) and synchronous active-low reset
//   cmd_valid/cmd_ready    command handshake; cmd_write/cmd_addr/cmd_wdata payload
//   rsp_valid              one-cycle response pulse
//   rsp_rdata              read data (0 for writes and timeouts), held until next rsp
//   rsp_slverr             slave error or timeout, held until next rsp
//   rsp_timeout            transfer aborted by timeout, held until next rsp
//   busy                   transfer in progress
//   p_sel .. p_wdata       APB requester outputs
//   p_rdata/p_ready/p_slverr  APB completer responses (sampled only in ACCESS)

module apb_master_bridge #(
   parameter int unsigned ADDR_W         = 32,
   parameter int unsigned DATA_W         = 32,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic              p_clk,
   input  logic              p_reset,
   // Command side
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   // Response side
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_slverr,
   output logic              rsp_timeout,
   output logic              busy,
   // APB requester
   output logic              p_sel,
   output logic              p_enable,
   output logic              p_write,
   output logic [ADDR_W-1:0] p_add,
   output logic [DATA_W-1:0] p_wdata,
   input  logic [DATA_W-1:0] p_rdata,
   input  logic              p_ready,
   input  logic              p_slverr
);

   // A zero limit would abort before the completer is ever sampled.
   if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
      $error("apb_master_bridge: TIMEOUT_CYCLES must be >= 1");
   end

   typedef enum logic [1:0] {
      StIdle,
      StSetup,
      StAccess
   } state_e;

   state_e              state_q, state_d;
   logic                p_write_q, p_write_d;
   logic [ADDR_W-1:0]   p_add_q, p_add_d;
   logic [DATA_W-1:0]   p_wdata_q, p_wdata_d;
   logic                rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
   logic                rsp_slverr_q, rsp_slverr_d;
   logic                rsp_timeout_q, rsp_timeout_d;
   logic                timeout_hit;

`ifdef APB_MASTER_BRIDGE_TIMEOUT_EN
   // Counter only needs to hold 0..TIMEOUT_CYCLES-1: the abort fires on the
   // cycle the count would reach the limit.
   localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

   logic [CntW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (state_q == StSetup) begin
         cnt_d = '0;
      end else if ((state_q == StAccess) && !p_ready) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge p_clk) begin
      if (!p_reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign timeout_hit = (state_q == StAccess) && !p_ready && (cnt_q == CntLast);
`else
   assign timeout_hit = 1'b0;
`endif

   // Handshake and APB strobes are decoded from registered state only, so
   // p_ready never reaches p_sel/p_enable combinationally.
   assign cmd_ready   = (state_q == StIdle);
   assign busy        = (state_q != StIdle);
   assign p_sel       = (state_q != StIdle);
   assign p_enable    = (state_q == StAccess);
   assign p_write     = p_write_q;
   assign p_add       = p_add_q;
   assign p_wdata     = p_wdata_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_rdata   = rsp_rdata_q;
   assign rsp_slverr  = rsp_slverr_q;
   assign rsp_timeout = rsp_timeout_q;

   always_comb begin
      state_d       = state_q;
      p_write_d     = p_write_q;
      p_add_d       = p_add_q;
      p_wdata_d     = p_wdata_q;
      rsp_valid_d   = 1'b0;
      rsp_rdata_d   = rsp_rdata_q;
      rsp_slverr_d  = rsp_slverr_q;
      rsp_timeout_d = rsp_timeout_q;

      unique case (state_q)
         StIdle: begin
            if (cmd_valid) begin
               p_write_d = cmd_write;
               p_add_d   = cmd_addr;
               p_wdata_d = cmd_wdata;
               state_d   = StSetup;
            end
         end
         StSetup: begin
            state_d = StAccess;
         end
         StAccess: begin
            // Completion takes priority over a timeout on the same cycle.
            if (p_ready) begin
               state_d       = StIdle;
               rsp_valid_d   = 1'b1;
               rsp_rdata_d   = p_write_q ? '0 : p_rdata;
               rsp_slverr_d  = p_slverr;
               rsp_timeout_d = 1'b0;
            end else if (timeout_hit) begin
               state_d       = StIdle;
               rsp_valid_d   = 1'b1;
               rsp_rdata_d   = '0;
               rsp_slverr_d  = 1'b1;
               rsp_timeout_d = 1'b1;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge p_clk) begin
      if (!p_reset) begin
         state_q       <= StIdle;
         p_write_q     <= 1'b0;
         p_add_q       <= '0;
         p_wdata_q     <= '0;
         rsp_valid_q   <= 1'b0;
         rsp_rdata_q   <= '0;
         rsp_slverr_q  <= 1'b0;
         rsp_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         p_write_q     <= p_write_d;
         p_add_q       <= p_add_d;
         p_wdata_q     <= p_wdata_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_rdata_q   <= rsp_rdata_d;
         rsp_slverr_q  <= rsp_slverr_d;
         rsp_timeout_q <= rsp_timeout_d;
      end
   end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Testbench for apb_master_bridge: randomized commands against a word-array
// reference model, with an APB completer model that inserts planned wait
// states and errors. Expected responses are queued at issue time and popped
// by a negedge monitor whenever rsp_valid is seen.
`timescale 1ns/1ps

module tb_apb_master_bridge;

   localparam int unsigned ADDR_W         = 32;
   localparam int unsigned DATA_W         = 32;
   localparam int unsigned TIMEOUT_CYCLES = 4;

   logic              p_clk = 1'b0;
   logic              p_reset;
   logic              cmd_valid, cmd_ready, cmd_write;
   logic [ADDR_W-1:0] cmd_addr;
   logic [DATA_W-1:0] cmd_wdata;
   logic              rsp_valid, rsp_slverr, rsp_timeout, busy;
   logic [DATA_W-1:0] rsp_rdata;
   logic              p_sel, p_enable, p_write;
   logic [ADDR_W-1:0] p_add;
   logic [DATA_W-1:0] p_wdata, p_rdata;
   logic              p_ready, p_slverr;

   apb_master_bridge #(
      .ADDR_W         (ADDR_W),
      .DATA_W         (DATA_W),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) dut (
      .p_clk       (p_clk),
      .p_reset     (p_reset),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_write   (cmd_write),
      .cmd_addr    (cmd_addr),
      .cmd_wdata   (cmd_wdata),
      .rsp_valid   (rsp_valid),
      .rsp_rdata   (rsp_rdata),
      .rsp_slverr  (rsp_slverr),
      .rsp_timeout (rsp_timeout),
      .busy        (busy),
      .p_sel       (p_sel),
      .p_enable    (p_enable),
      .p_write     (p_write),
      .p_add       (p_add),
      .p_wdata     (p_wdata),
      .p_rdata     (p_rdata),
      .p_ready     (p_ready),
      .p_slverr    (p_slverr)
   );

   always #5 p_clk = ~p_clk;

   typedef struct {
      logic [31:0] rdata;
      logic        slverr;
      logic        timeout;
      int unsigned cyc;
   } rsp_t;

   typedef struct {
      int unsigned waits;
      logic        err;
   } plan_t;

   rsp_t        exp_q[$];
   plan_t       plan_q[$];
   logic [31:0] ref_mem [16];
   logic [31:0] slv_mem [16];

   int unsigned cyc = 0;
   int unsigned n_checks = 0;
   int unsigned n_pass = 0;
   bit          chk_en = 1'b0;
   bit          cur_active = 1'b0;
   int unsigned cur_t = 0, cur_last = 0;
   logic        cur_write = 1'b0;
   logic [31:0] cur_addr = '0, cur_wdata = '0;
   logic [31:0] last_rdata = '0;
   logic        last_slverr = 1'b0, last_timeout = 1'b0;
   int unsigned slv_wait = 0;
   logic        slv_err = 1'b0;

   always @(posedge p_clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // APB completer: waits/errors come from the plan queued with each command;
   // outside ACCESS it drives junk that the bridge must ignore.
   always @(posedge p_clk) begin
      plan_t pl;
      if (p_sel && p_enable && p_ready && p_write && !p_slverr) slv_mem[p_add[5:2]] = p_wdata;
      #1;
      if (p_sel && p_enable) begin
         if (slv_wait == 0) begin
            p_ready  = 1'b1;
            p_slverr = slv_err;
            p_rdata  = slv_mem[p_add[5:2]];
         end else begin
            p_ready  = 1'b0;
            p_slverr = 1'($urandom);
            p_rdata  = $urandom;
            slv_wait--;
         end
      end else begin
         p_ready  = 1'($urandom);
         p_slverr = 1'($urandom);
         p_rdata  = $urandom;
         if (p_sel) begin
            if (plan_q.size() > 0) begin
               pl       = plan_q.pop_front();
               slv_wait = pl.waits;
               slv_err  = pl.err;
            end else begin
               slv_wait = 0;
               slv_err  = 1'b0;
            end
         end
      end
   end

   // Monitor: scoreboard pop on rsp_valid, plus per-cycle phase/bus checks.
   always @(negedge p_clk) begin
      rsp_t       e;
      logic [3:0] exp_ph;
      if (rsp_valid) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL rsp_unexpected: got rsp_valid=1, want 0 (cycle %0d)", cyc);
         end else begin
            e = exp_q.pop_front();
            check("rsp_fields{rdata,slverr,timeout}", {rsp_rdata, rsp_slverr, rsp_timeout},
                  {e.rdata, e.slverr, e.timeout});
            check("rsp_cycle", 128'(cyc), 128'(e.cyc));
            check("rsp_cmd_ready", 128'(cmd_ready), 128'(1));
            last_rdata   = e.rdata;
            last_slverr  = e.slverr;
            last_timeout = e.timeout;
         end
      end else if (chk_en) begin
         check("rsp_hold", {rsp_rdata, rsp_slverr, rsp_timeout},
               {last_rdata, last_slverr, last_timeout});
      end
      if (chk_en) begin
         if (cur_active && cyc == cur_t + 1) exp_ph = 4'b1010;
         else if (cur_active && cyc >= cur_t + 2 && cyc <= cur_last) exp_ph = 4'b1110;
         else exp_ph = 4'b0001;
         check("phase{sel,en,busy,ready}", {p_sel, p_enable, busy, cmd_ready}, 128'(exp_ph));
         if (exp_ph[3]) begin
            check("bus{write,addr,wdata}", {p_write, p_add, p_wdata},
                  {cur_write, cur_addr, cur_wdata});
         end
      end
   end

   // Called at posedge+1. Junk is driven on cmd_* while the bridge is busy.
   task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input int unsigned waits, input logic err);
      int unsigned guard = 0;
      logic        to;
      rsp_t        e;
      plan_t       pl;
      while (!cmd_ready) begin
         cmd_valid = 1'($urandom);
         cmd_write = 1'($urandom);
         cmd_addr  = $urandom;
         cmd_wdata = $urandom;
         @(posedge p_clk); #1;
         guard++;
         if (guard > 300) begin
            n_checks++;
            $display("FAIL issue_wait: cmd_ready=0 after %0d cycles, want 1", guard);
            return;
         end
      end
      cmd_valid = 1'b1;
      cmd_write = wr;
      cmd_addr  = addr;
      cmd_wdata = wdata;
`ifdef APB_MASTER_BRIDGE_TIMEOUT_EN
      to = (waits >= TIMEOUT_CYCLES);
`else
      to = 1'b0;
`endif
      e.timeout = to;
      e.slverr  = to | err;
      e.rdata   = (wr || to) ? 32'h0 : ref_mem[addr[5:2]];
      e.cyc     = to ? cyc + 2 + TIMEOUT_CYCLES : cyc + 3 + waits;
      if (wr && !err && !to) ref_mem[addr[5:2]] = wdata;
      cur_t      = cyc;
      cur_last   = to ? cyc + 1 + TIMEOUT_CYCLES : cyc + 2 + waits;
      cur_write  = wr;
      cur_addr   = addr;
      cur_wdata  = wdata;
      cur_active = 1'b1;
      exp_q.push_back(e);
      pl.waits = waits;
      pl.err   = err;
      plan_q.push_back(pl);
      @(posedge p_clk); #1;
      cmd_valid = 1'b0;
      cmd_write = 1'($urandom);
      cmd_addr  = $urandom;
      cmd_wdata = $urandom;
   endtask

   initial begin
      int unsigned gap;
      int unsigned guard;
      for (int i = 0; i < 16; i++) begin
         ref_mem[i] = '0;
         slv_mem[i] = '0;
      end
      p_reset   = 1'b0;
      cmd_valid = 1'b0;
      cmd_write = 1'b0;
      cmd_addr  = '0;
      cmd_wdata = '0;
      p_ready   = 1'b0;
      p_slverr  = 1'b0;
      p_rdata   = '0;
      repeat (3) @(posedge p_clk);
      #1;
      check("reset_ctrl{sel,en,busy,rv,err,to,wr,ready}",
            {p_sel, p_enable, busy, rsp_valid, rsp_slverr, rsp_timeout, p_write, cmd_ready},
            128'h01);
      check("reset_data{add,wdata,rdata}", {p_add, p_wdata, rsp_rdata}, 128'h0);
      p_reset = 1'b1;
      @(posedge p_clk); #1;
      chk_en = 1'b1;

      // Directed cases
      issue(1'b1, 32'h04, 32'hDEADBEEF, 0, 1'b0);
      issue(1'b0, 32'h04, $urandom, 0, 1'b0);
      issue(1'b0, 32'h04, $urandom, 3, 1'b0);
      issue(1'b1, 32'h10, 32'hCAFEF00D, 0, 1'b1);
      issue(1'b0, 32'h10, $urandom, 0, 1'b0);
      issue(1'b0, 32'h20, $urandom, 110, 1'b0);

      // Randomized traffic
      for (int n = 0; n < 60; n++) begin
         gap = $urandom_range(0, 2);
         repeat (gap) begin
            @(posedge p_clk); #1;
         end
         issue(1'($urandom), ($urandom % 16) << 2, $urandom, $urandom_range(0, 5),
               1'(($urandom % 8) == 0));
      end

      // Reset during ACCESS: the read is abandoned with no response.
      issue(1'b0, 32'h08, 32'h5A5A_A5A5, 20, 1'b0);
      @(posedge p_clk); #1;
      @(posedge p_clk); #1;
      check("pre_reset_access{sel,en}", {p_sel, p_enable}, 128'b11);
      chk_en     = 1'b0;
      p_reset    = 1'b0;
      cur_active = 1'b0;
      exp_q.delete(exp_q.size() - 1);
      @(posedge p_clk); #1;
      check("midreset_ctrl{sel,en,busy,rv,err,to,wr}",
            {p_sel, p_enable, busy, rsp_valid, rsp_slverr, rsp_timeout, p_write}, 128'h0);
      check("midreset_data{add,wdata,rdata}", {p_add, p_wdata, rsp_rdata}, 128'h0);
      @(posedge p_clk); #1;
      p_reset = 1'b1;
      @(posedge p_clk); #1;
      check("post_reset_cmd_ready", 128'(cmd_ready), 128'(1));
      last_rdata   = '0;
      last_slverr  = 1'b0;
      last_timeout = 1'b0;
      chk_en       = 1'b1;

      issue(1'b1, 32'h3C, 32'h1234_5678, 1, 1'b0);
      issue(1'b0, 32'h3C, $urandom, 2, 1'b0);

      guard = 0;
      while (exp_q.size() != 0 && guard < 300) begin
         @(posedge p_clk); #1;
         guard++;
      end
      check("drain_empty", 128'(exp_q.size()), 128'(0));
      repeat (3) @(posedge p_clk);
      #1;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
